// File: rtl/onehot_encoder_seq_if.sv
// Request/index handshake bundle for the sequential one-hot encoder.
// Master drives requests and consumes indices; slave is the encoder.
interface onehot_encoder_seq_if #(
  parameter int N = 4
);
  localparam int W = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         zero_err;

  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  zero_err
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last,
    output zero_err
  );
endinterface

// File: rtl/onehot_encoder_seq.sv
// Sequential encoder: emits the index of every set request bit,
// lowest first, one per handshake beat.
module onehot_encoder_seq #(
  parameter int N = 4
) (
  input logic              clk,
  input logic              rst,
  onehot_encoder_seq_if.slave bus
);
  localparam int W = $clog2(N);

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_t;

  state_t       r_state;
  logic [N-1:0] r_pending;
  logic         r_zero_err;

  logic [W-1:0] w_idx;
  logic [N-1:0] w_next;
  logic         w_last;
  logic         w_scan;
  logic         w_idle;

  // Lowest set bit of pending; x & (x-1) drops that bit.
  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pending[i]) w_idx = W'(i);
    end
    w_next = r_pending & (r_pending - N'(1));
    w_last = (r_pending != '0) && (w_next == '0);
  end

  assign w_idle = (r_state == S_IDLE) && !rst;
  assign w_scan = (r_state == S_SCAN) && !rst;

  assign bus.in_ready  = w_idle;
  assign bus.out_valid = w_scan;
  assign bus.out_idx   = w_scan ? w_idx : '0;
  assign bus.out_last  = w_scan ? w_last : 1'b0;
  assign bus.zero_err  = r_zero_err;

  // Accept a vector in IDLE, then retire one pending bit per beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_zero_err <= 1'b0;
    end else begin
      r_zero_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_vec != '0) begin
              r_pending <= bus.in_vec;
              r_state   <= S_SCAN;
            end else begin
              r_zero_err <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (bus.out_ready) begin
            r_pending <= w_next;
            if (w_last) r_state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule
